onchip_memory_scrub_master: RTL

Avalon-MM initiator that drives the single-port 32-bit × 1024-word on-chip memory slave from the other end of the bus. On a start command it fills a contiguous, wrapping word range with a deterministic pattern. Optionally it then reads the range back and compares it, reporting an error count and the first failing address. It sits beside the processor's on-chip RAM as a boot-time initialiser and memory self-test engine.

---
 rtl/onchip_mem_pkg.sv | 18 +
 rtl/onchip_memory_scrub_master_if.sv | 27 ++
 rtl/onchip_mem_pattern_gen.sv | 69 ++++++
 rtl/onchip_memory_scrub_master.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/onchip_mem_pkg.sv
// Shared definitions for the on-chip memory scrub master: FSM states and
// default geometry of the 32-bit x 1024-word memory slave.
package onchip_mem_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;
    localparam int MEM_WORDS  = 1024;
    localparam int RD_LATENCY = 1;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/onchip_memory_scrub_master_if.sv
// Avalon-MM bus between the scrub master and the on-chip memory slave.
interface onchip_memory_scrub_master_if
    import onchip_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic [ADDR_W-1:0]   m_address;
    logic [DATA_W/8-1:0] m_byteenable;
    logic                m_chipselect;
    logic                m_write;
    logic [DATA_W-1:0]   m_writedata;
    logic                m_clken;
    logic [DATA_W-1:0]   m_readdata;

    modport master (
        output m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken,
        input  m_readdata
    );

    modport slave (
        input  m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken,
        output m_readdata
    );

endinterface

// File: rtl/onchip_mem_pattern_gen.sv
// Word index, wrapping address and seed+i pattern generator shared by the
// write and read phases, plus the one-cycle delay of the expected
// address/data that lines up with the memory read latency.
module onchip_mem_pattern_gen
    import onchip_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic              rewind,
    input  logic              step,
    input  logic              track,
    input  logic [ADDR_W-1:0] base_in,
    input  logic [DATA_W-1:0] seed_in,
    output logic [ADDR_W:0]   idx,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              vld_p1,
    output logic [ADDR_W-1:0] exp_addr_p1,
    output logic [DATA_W-1:0] exp_data_p1
);

    logic [ADDR_W-1:0] base_q;
    logic [DATA_W-1:0] seed_q;

    // Load a new origin, rewind to it for the read pass, or advance one word
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q <= '0;
            seed_q <= '0;
            idx    <= '0;
            addr   <= '0;
            data   <= '0;
        end else if (capture) begin
            base_q <= base_in;
            seed_q <= seed_in;
            idx    <= '0;
            addr   <= base_in;
            data   <= seed_in;
        end else if (rewind) begin
            idx    <= '0;
            addr   <= base_q;
            data   <= seed_q;
        end else if (step) begin
            idx    <= idx + (ADDR_W+1)'(1);
            addr   <= addr + ADDR_W'(1);
            data   <= data + DATA_W'(1);
        end
    end

    // Read-valid flag follows the access by one cycle to meet the returned data
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= track;
        end
    end

    // Expected address/data delayed alongside the read access
    always_ff @(posedge clk) begin
        exp_addr_p1 <= addr;
        exp_data_p1 <= data;
    end

endmodule

// File: rtl/onchip_memory_scrub_master.sv
// Boot-time fill and optional read-back self-test of the on-chip RAM over
// Avalon-MM. All bus and status outputs are registered.
module onchip_memory_scrub_master
    import onchip_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              verify,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    onchip_memory_scrub_master_if.master bus
);

    // Word counts above the memory size collapse to a full-memory pass
    function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] l);
        logic [ADDR_W:0] max_len;
        max_len = {1'b1, {ADDR_W{1'b0}}};
        return (l > max_len) ? max_len : l;
    endfunction

    state_t            state, next_state;
    logic              verify_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   len_in;
    logic              capture, rewind, step, last;
    logic              cs_q, write_q;
    logic [ADDR_W:0]   idx;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              vld_p1;
    logic [ADDR_W-1:0] exp_addr_p1;
    logic [DATA_W-1:0] exp_data_p1;

    assign len_in = clamp_len(length);
    assign last   = (idx == len_q - (ADDR_W+1)'(1));

    onchip_mem_pattern_gen #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_pattern (
        .clk         (clk),
        .rst         (reset),
        .capture     (capture),
        .rewind      (rewind),
        .step        (step),
        .track       (state == READ),
        .base_in     (base_addr),
        .seed_in     (seed),
        .idx         (idx),
        .addr        (addr),
        .data        (data),
        .vld_p1      (vld_p1),
        .exp_addr_p1 (exp_addr_p1),
        .exp_data_p1 (exp_data_p1)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and pattern-generator controls; DONE accepts a start like IDLE
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        rewind     = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE, DONE: begin
                next_state = IDLE;
                if (start) begin
                    capture    = 1'b1;
                    next_state = (len_in == '0) ? DONE : WRITE;
                end
            end
            WRITE: begin
                if (last) begin
                    if (verify_q) begin
                        rewind     = 1'b1;
                        next_state = READ;
                    end else begin
                        next_state = DONE;
                    end
                end else begin
                    step = 1'b1;
                end
            end
            READ: begin
                if (last) begin
                    next_state = DRAIN;
                end else begin
                    step = 1'b1;
                end
            end
            DRAIN:   next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    // Command capture
    always_ff @(posedge clk) begin
        if (reset) begin
            verify_q <= 1'b0;
            len_q    <= '0;
        end else if (capture) begin
            verify_q <= verify;
            len_q    <= len_in;
        end
    end

    // Registered status and bus strobes, decoded from the upcoming state
    always_ff @(posedge clk) begin
        if (reset) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            cs_q    <= 1'b0;
            write_q <= 1'b0;
        end else begin
            busy    <= (next_state == WRITE) || (next_state == READ) || (next_state == DRAIN);
            done    <= (next_state == DONE);
            cs_q    <= (next_state == WRITE) || (next_state == READ);
            write_q <= (next_state == WRITE);
        end
    end

    // Read-back compare one cycle after each read; first mismatch address latched once
    always_ff @(posedge clk) begin
        if (reset || capture) begin
            err_count      <= '0;
            first_err_addr <= '0;
        end else if (vld_p1 && (bus.m_readdata != exp_data_p1)) begin
            err_count <= err_count + (ADDR_W+1)'(1);
            if (err_count == '0) begin
                first_err_addr <= exp_addr_p1;
            end
        end
    end

    assign bus.m_address    = addr;
    assign bus.m_writedata  = data;
    assign bus.m_chipselect = cs_q;
    assign bus.m_write      = write_q;
    assign bus.m_byteenable = '1;
    assign bus.m_clken      = 1'b1;

endmodule
